multi_op_unit: RTL and testbench
================================

MULTI_OP_UNIT -- requirements
Module: multi_op_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath width (even, >=4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command-queue depth (power of two, >=2).
REQ-003 SHALL have parameter SH_W, default $clog2(DATA_W), shift-amount width.
REQ-004 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port op_start  input  1  command valid.
REQ-007 SHALL have port op_ready  output  1  command accepted when op_start && op_ready.
REQ-008 SHALL have port op_code  input  3  operation select.
REQ-009 SHALL have port shamt  input  SH_W  shift/rotate amount.
REQ-010 SHALL have port data_in  input  DATA_W  operand.
REQ-011 SHALL have port data_out  output  DATA_W  result.
REQ-012 SHALL have port data_valid  output  1  result valid.
REQ-013 SHALL have port data_ready  input  1  downstream accepts result.
REQ-014 SHALL have port op_err  output  1  result came from reserved op_code; qualified by data_valid.
REQ-015 SHALL have port ack_toggle  output  1  flips on every output handshake.
REQ-016 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  queued command count.

Function
REQ-017 SHALL store {op_code, shamt, data_in} in the command FIFO on each accepted command; op_ready = !full.
REQ-018 SHALL pop the FIFO and register a result when not empty and the output register is empty or handshaking that cycle (data_valid && data_ready).
REQ-019 SHALL give two-cycle latency: command accepted at edge N with FIFO empty and output free -> data_valid high after edge N+1.
REQ-020 SHALL sustain one result per cycle with data_ready held high.
REQ-021 SHALL hold data_out, op_err and data_valid stable while data_valid && !data_ready.
REQ-022 SHALL implement ops: 000 pass; 001 SHL zero-fill; 010 SHR logical zero-fill; 011 ROL; 100 ROR; 101 bitwise invert; 110 swap upper/lower halves; 111 reserved -> data_out = data_in, op_err=1.
REQ-023 SHALL treat shamt >= DATA_W as: shifts -> all zeros; rotates -> modulo DATA_W; shamt 0 -> data unchanged.
REQ-024 SHALL ignore shamt for ops 000, 101, 110, 111.
REQ-025 SHALL return results in command order with no bypass of the FIFO.
REQ-026 SHALL, on simultaneous push and pop, keep fifo_level unchanged; op_ready SHALL remain !full (no push-when-full even with pop).
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH with no loss or duplication.
REQ-028 SHALL toggle ack_toggle on the edge completing a data_valid && data_ready handshake, and only then.

Reset
REQ-029 SHALL on rst assertion immediately clear: FIFO empty, fifo_level=0, op_ready=1 after release, data_valid=0, data_out=0, op_err=0, ack_toggle=0.
REQ-030 SHALL discard all queued and in-flight commands on reset mid-operation; no result emitted for them.

Configuration
REQ-031 SHALL, with OPU_PARITY_EN defined, add output data_par (1 bit) = XOR-reduce of data_out, registered with data_out and held under backpressure.
REQ-032 SHALL, without OPU_PARITY_EN, omit data_par entirely; other behaviour identical.

Structure
REQ-033 SHALL place the op_code enumeration (OP_PASS..OP_RSVD) and the op_code width constant in shared package opu_pkg.
REQ-034 SHALL implement the queue as sub-module opu_cmd_fifo (parameters width, depth; ports push, pop, full, empty, level).

Verification (DATA_W=8, FIFO_DEPTH=4)
REQ-035 SHALL cover: op 001, shamt 2, data 0xCC -> data_out 0x30, op_err 0, data_valid two cycles after accept.
REQ-036 SHALL cover: op 100, shamt 2, data 0xB3 -> 0xEC; op 011, shamt 10, data 0x81 -> 0x06.
REQ-037 SHALL cover: op 101, data 0x55, data_ready high -> 0xAA, ack_toggle 0->1; then op 110, 0x3C -> 0xC3, ack_toggle 1->0.
REQ-038 SHALL cover: data_ready=0, six back-to-back commands -> five accepted (4 queued + 1 output), op_ready=0, fifo_level=4; release data_ready -> five results in order, one per cycle.
REQ-039 SHALL cover: op 111, data 0x5A -> data_out 0x5A, op_err 1; op 010, shamt 9, data 0xFF -> 0x00.
REQ-040 SHALL cover: rst asserted with three commands queued and data_valid high -> all outputs at reset values within the cycle, no stale result after release.

Source files
------------

// File: rtl/opu_pkg.sv
// opu_pkg: shared definitions for multi_op_unit.
//   OP_W  - width of the op_code field
//   op_e  - operation encoding (OP_PASS .. OP_RSVD)
package opu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_PASS = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_INV  = 3'b101,
    OP_SWAP = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

endpackage

// File: rtl/opu_cmd_fifo.sv
// opu_cmd_fifo: synchronous command queue, power-of-two depth.
//   clk, rst     - clock, async active-high reset
//   push, wdata  - write request (ignored when full)
//   pop, rdata   - read request (ignored when empty); rdata shows the head
//   full, empty  - occupancy flags
//   level        - number of stored entries (0..DEPTH)
module opu_cmd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/multi_op_unit.sv
// multi_op_unit: queued shift/rotate/logic unit with a registered,
// back-pressured result stage.
//   clk, rst            - clock, async active-high reset
//   op_start/op_ready   - command handshake; op_code, shamt, data_in captured
//   data_out/data_valid - result, held while data_ready is low
//   data_ready          - downstream accept
//   op_err              - result came from the reserved op_code
//   ack_toggle          - flips on every output handshake
//   fifo_level          - commands waiting in the queue
//   data_par            - XOR of data_out (only with OPU_PARITY_EN defined)
module multi_op_unit
  import opu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SH_W       = $clog2(DATA_W)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        op_start,
  output logic                        op_ready,
  input  logic [OP_W-1:0]             op_code,
  input  logic [SH_W-1:0]             shamt,
  input  logic [DATA_W-1:0]           data_in,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic                        op_err,
  output logic                        ack_toggle,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef OPU_PARITY_EN
  ,
  output logic                        data_par
`endif
);

  localparam int CMD_W = OP_W + SH_W + DATA_W;
  localparam int HALF  = DATA_W / 2;

  logic [CMD_W-1:0]  cmd_w, cmd_r;
  logic              fifo_full, fifo_empty, push, pop;
  logic [OP_W-1:0]   c_op;
  logic [SH_W-1:0]   c_sh;
  logic [DATA_W-1:0] c_data;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d, err_q, err_d, ack_q, ack_d;

  function automatic logic [DATA_W-1:0] op_result(
    input logic [OP_W-1:0]   op,
    input logic [SH_W-1:0]   sh,
    input logic [DATA_W-1:0] d
  );
    logic [2*DATA_W-1:0] dd;
    logic [DATA_W-1:0]   r;
    int                  amt, rot;
    amt = int'(sh);
    rot = amt % DATA_W;
    dd  = {d, d};
    case (op)
      OP_SHL:  r = (amt >= DATA_W) ? '0 : (d << amt);
      OP_SHR:  r = (amt >= DATA_W) ? '0 : (d >> amt);
      // Rotates shift a doubled copy and take the window that wraps around.
      OP_ROL:  begin dd = dd << rot; r = dd[2*DATA_W-1:DATA_W]; end
      OP_ROR:  begin dd = dd >> rot; r = dd[DATA_W-1:0];        end
      OP_INV:  r = ~d;
      OP_SWAP: r = {d[HALF-1:0], d[DATA_W-1:HALF]};
      default: r = d;  // OP_PASS and OP_RSVD
    endcase
    return r;
  endfunction

  assign cmd_w = {op_code, shamt, data_in};
  assign {c_op, c_sh, c_data} = cmd_r;

  assign op_ready = !fifo_full;
  assign push     = op_start && !fifo_full;
  // Refill the output stage whenever it is empty or draining this cycle.
  assign pop      = !fifo_empty && (!vld_q || data_ready);

  opu_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (cmd_w),
    .pop   (pop),
    .rdata (cmd_r),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    dout_d = dout_q;
    vld_d  = vld_q;
    err_d  = err_q;
    ack_d  = ack_q;
    if (vld_q && data_ready) begin
      vld_d = 1'b0;
      ack_d = ~ack_q;
    end
    if (pop) begin
      vld_d  = 1'b1;
      dout_d = op_result(c_op, c_sh, c_data);
      err_d  = (c_op == OP_RSVD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
      ack_q  <= ack_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = vld_q;
  assign op_err     = err_q;
  assign ack_toggle = ack_q;

`ifdef OPU_PARITY_EN
  // Registered alongside data_out so it is held under backpressure too.
  logic par_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      par_q <= 1'b0;
    else if (pop) par_q <= ^dout_d;
  end
  assign data_par = par_q;
`endif

endmodule

// File: tb/tb_multi_op_unit.sv
module tb_multi_op_unit;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int SHW = 4;  // wide enough to express shamt >= DATA_W

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           op_start = 1'b0;
  logic           op_ready;
  logic [2:0]     op_code = '0;
  logic [SHW-1:0] shamt = '0;
  logic [DW-1:0]  data_in = '0;
  logic [DW-1:0]  data_out;
  logic           data_valid;
  logic           data_ready = 1'b0;
  logic           op_err;
  logic           ack_toggle;
  logic [2:0]     fifo_level;
`ifdef OPU_PARITY_EN
  logic           data_par;
`endif

  int total = 0;
  int bad = 0;

  multi_op_unit #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SH_W(SHW)) dut (
    .clk(clk), .rst(rst), .op_start(op_start), .op_ready(op_ready),
    .op_code(op_code), .shamt(shamt), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .op_err(op_err), .ack_toggle(ack_toggle), .fifo_level(fifo_level)
`ifdef OPU_PARITY_EN
    , .data_par(data_par)
`endif
  );

  always #5 clk = ~clk;

  // Reference: results derived directly from the operation definitions.
  function automatic void ref_calc(input int op, input int sh, input int d,
                                   output int r, output bit e);
    int k;
    k = sh % DW;
    e = 1'b0;
    case (op)
      0: r = d;
      1: r = (sh >= DW) ? 0 : ((d << sh) & 255);
      2: r = (sh >= DW) ? 0 : (d >> sh);
      3: r = ((d << k) | (d >> (DW - k))) & 255;
      4: r = ((d >> k) | (d << (DW - k))) & 255;
      5: r = (~d) & 255;
      6: r = ((d & 15) << 4) | (d >> 4);
      default: begin r = d; e = 1'b1; end
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", data_valid); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", data_out); end
    total++; if (op_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", op_err); end
    total++; if (ack_toggle !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", ack_toggle); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", op_ready); end
  endtask

  task automatic test_ack();
    logic [2:0] ops [2];
    logic [7:0] din [2];
    logic [7:0] want [2];
    logic       ack_before [2];
    ops[0] = 3'b101; din[0] = 8'h55; want[0] = 8'hAA; ack_before[0] = 1'b0;
    ops[1] = 3'b110; din[1] = 8'h3C; want[1] = 8'hC3; ack_before[1] = 1'b1;
    data_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      op_start = 1'b1; op_code = ops[i]; shamt = 4'(i + 3); data_in = din[i];
      @(negedge clk);
      op_start = 1'b0;
      @(negedge clk);
      total++; if (data_out !== want[i] || data_valid !== 1'b1) begin bad++;
        $display("FAIL ack_result%0d got=%h/%b want=%h/1", i, data_out, data_valid, want[i]); end
      total++; if (ack_toggle !== ack_before[i]) begin bad++;
        $display("FAIL ack_pre%0d got=%b want=%b", i, ack_toggle, ack_before[i]); end
      @(negedge clk);
      total++; if (ack_toggle !== ~ack_before[i]) begin bad++;
        $display("FAIL ack_post%0d got=%b want=%b", i, ack_toggle, ~ack_before[i]); end
    end
  endtask

  task automatic test_ops();
    logic [2:0]     ops [5];
    logic [SHW-1:0] sh [5];
    logic [7:0]     din [5];
    logic [7:0]     want [5];
    logic           werr [5];
    ops[0] = 3'b001; sh[0] = 4'd2;  din[0] = 8'hCC; want[0] = 8'h30; werr[0] = 1'b0;
    ops[1] = 3'b100; sh[1] = 4'd2;  din[1] = 8'hB3; want[1] = 8'hEC; werr[1] = 1'b0;
    ops[2] = 3'b011; sh[2] = 4'd10; din[2] = 8'h81; want[2] = 8'h06; werr[2] = 1'b0;
    ops[3] = 3'b111; sh[3] = 4'd5;  din[3] = 8'h5A; want[3] = 8'h5A; werr[3] = 1'b1;
    ops[4] = 3'b010; sh[4] = 4'd9;  din[4] = 8'hFF; want[4] = 8'h00; werr[4] = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op_start = 1'b1; op_code = ops[i]; shamt = sh[i]; data_in = din[i];
      @(negedge clk);
      op_start = 1'b0;
      total++; if (data_valid !== 1'b0) begin bad++;
        $display("FAIL ops_early%0d got=%b want=0", i, data_valid); end
      @(negedge clk);
      total++; if (data_valid !== 1'b1 || data_out !== want[i] || op_err !== werr[i]) begin bad++;
        $display("FAIL ops_result%0d got=%b/%h/%b want=1/%h/%b", i, data_valid, data_out, op_err, want[i], werr[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int   exp_q[$];
    int   r, accepted;
    bit   e;
    logic ack0;
    logic [7:0] held;
    data_ready = 1'b0;
    accepted = 0;
    ack0 = ack_toggle;
    for (int i = 0; i < 6; i++) begin
      op_start = 1'b1; op_code = 3'($urandom_range(0, 6));
      shamt = 4'($urandom_range(0, 15)); data_in = 8'($urandom);
      if (op_ready) begin
        ref_calc(int'(op_code), int'(shamt), int'(data_in), r, e);
        exp_q.push_back(r);
        accepted++;
      end
      @(negedge clk);
    end
    op_start = 1'b0;
    total++; if (accepted != 5) begin bad++; $display("FAIL bp_accepted got=%0d want=5", accepted); end
    total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", op_ready); end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL bp_level got=%0d want=4", fifo_level); end
    held = data_out;
    repeat (3) @(negedge clk);
    total++; if (data_valid !== 1'b1 || data_out !== held || ack_toggle !== ack0) begin bad++;
      $display("FAIL bp_hold got=%b/%h/%b want=1/%h/%b", data_valid, data_out, ack_toggle, held, ack0); end
    data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (data_valid !== 1'b1 || data_out !== 8'(exp_q[i])) begin bad++;
        $display("FAIL bp_drain%0d got=%b/%h want=1/%h", i, data_valid, data_out, exp_q[i]); end
      @(negedge clk);
    end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", data_valid); end
  endtask

  task automatic test_reset_mid();
    data_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_start = 1'b1; op_code = 3'b000; shamt = '0; data_in = 8'(8'h11 * (i + 1));
      @(negedge clk);
    end
    op_start = 1'b0;
    total++; if (data_valid !== 1'b1 || fifo_level !== 3'd3) begin bad++;
      $display("FAIL rm_pre got=%b/%0d want=1/3", data_valid, fifo_level); end
    #1 rst = 1'b1;
    #1;
    total++; if (data_valid !== 1'b0 || data_out !== 8'h00 || op_err !== 1'b0 ||
                 ack_toggle !== 1'b0 || fifo_level !== 3'd0) begin bad++;
      $display("FAIL rm_async got=%b/%h/%b/%b/%0d want=0/00/0/0/0",
               data_valid, data_out, op_err, ack_toggle, fifo_level); end
    @(negedge clk);
    rst = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (data_valid !== 1'b0 || fifo_level !== 3'd0 || op_ready !== 1'b1) begin bad++;
        $display("FAIL rm_stale%0d got=%b/%0d/%b want=0/0/1", i, data_valid, fifo_level, op_ready); end
    end
  endtask

  task automatic test_random();
    int   exp_q[$];
    bit   err_q[$];
    int   r, n;
    bit   e, exp_ack;
    exp_ack = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc < 360) begin
        op_start = 1'($urandom_range(0, 1)); op_code = 3'($urandom_range(0, 7));
        shamt = 4'($urandom_range(0, 15)); data_in = 8'($urandom);
        data_ready = ($urandom_range(0, 3) != 0);
      end else begin
        op_start = 1'b0; data_ready = 1'b1;
      end
      n = exp_q.size() - int'(data_valid);
      total++; if (int'(fifo_level) != n) begin bad++;
        $display("FAIL rnd_level c%0d got=%0d want=%0d", cyc, fifo_level, n); end
      total++; if (ack_toggle !== exp_ack) begin bad++;
        $display("FAIL rnd_ack c%0d got=%b want=%b", cyc, ack_toggle, exp_ack); end
      if (data_valid && data_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_extra c%0d got=%h want=none", cyc, data_out); end
        else begin
          if (data_out !== 8'(exp_q[0]) || op_err !== err_q[0]) begin bad++;
            $display("FAIL rnd_data c%0d got=%h/%b want=%h/%b", cyc, data_out, op_err, exp_q[0], err_q[0]); end
          void'(exp_q.pop_front()); void'(err_q.pop_front());
        end
        exp_ack = ~exp_ack;
      end
      if (op_start && op_ready) begin
        ref_calc(int'(op_code), int'(shamt), int'(data_in), r, e);
        exp_q.push_back(r); err_q.push_back(e);
      end
    end
    total++; if (exp_q.size() != 0 || data_valid !== 1'b0) begin bad++;
      $display("FAIL rnd_drain got=%0d/%b want=0/0", exp_q.size(), data_valid); end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_ops();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
